mips_instr_encoder: RTL and testbench
=====================================

Name: mips_instr_encoder

Overview:
Program loader for the P4 single-cycle core. Accepts symbolic instructions (kind code plus fields) over a valid/ready stream, encodes each into a 32-bit MIPS word for the core's supported subset, and writes the words sequentially into instruction memory. It is the encoding counterpart of the core's control decoder: every word it emits decodes back to the same kind.

Parameters:
DEPTH, 1024, instruction-memory capacity in words; the load stops when this many words have been written.
ADDR_W, 10, word-address width; must equal clog2(DEPTH).

Ports:
clk  in  1  clock; all state changes on the rising edge.
reset_n  in  1  asynchronous, active-low reset.
start  in  1  pulse: begin a new load at word address 0; clears counters and error flag.
finish  in  1  pulse: end the current load.
in_valid  in  1  instruction beat valid.
in_ready  out  1  beat accepted on a cycle where in_valid && in_ready.
kind  in  4  0 NOP, 1 ADD, 2 SUB, 3 JR, 4 ORI, 5 LW, 6 SW, 7 BEQ, 8 LUI, 9 JAL; 10-15 illegal.
rs  in  5  source register.
rt  in  5  target register.
rd  in  5  destination register (ADD/SUB only).
imm  in  16  immediate (ORI/LW/SW/BEQ/LUI).
target  in  26  jump target field (JAL).
im_we  out  1  instruction-memory write enable.
im_addr  out  ADDR_W  word address of the write.
im_wdata  out  32  encoded instruction.
busy  out  1  high in LOAD or FULL.
full  out  1  high in FULL.
words_written  out  ADDR_W+1  number of words written in the current load.
err_illegal  out  1  sticky: an illegal kind was accepted.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-load): state IDLE; all outputs 0; im_we drops at once and any pending write is discarded.
- FSM states:
  - IDLE: in_ready=0. start -> LOAD, with the address counter, words_written and err_illegal cleared.
  - LOAD: in_ready=1. Each accepted legal beat writes one word. finish -> IDLE. When words_written reaches DEPTH -> FULL.
  - FULL: in_ready=0, full=1. finish -> IDLE. start -> LOAD with counters cleared.
- Priority: start over finish over beat acceptance. A start in LOAD restarts the load; a beat on that same cycle is not written.
- Latency: a beat accepted in cycle N drives im_we=1 with im_addr/im_wdata registered in cycle N+1, for exactly one cycle. The instruction memory never stalls.
- Address: im_addr equals the pre-increment counter value; the counter increments by 1 per legal word. The address never wraps; FULL blocks further input. The transition to FULL happens on the same edge as the DEPTH-th write.
- If finish is asserted on the cycle after the last beat, that last word is still written.
- Illegal kind: the beat is consumed (ready=1), no write occurs, the counter is unchanged, and err_illegal is set until the next start or reset.
- Encodings (shamt is always 0):
  - ADD: {000000, rs, rt, rd, 00000, 100000}
  - SUB: {000000, rs, rt, rd, 00000, 100010}
  - JR: {000000, rs, 15'b0, 001000}
  - NOP: 32'h0
  - ORI: {001101, rs, rt, imm}
  - LW: {100011, rs, rt, imm}
  - SW: {101011, rs, rt, imm}
  - BEQ: {000100, rs, rt, imm}
  - LUI: {001111, 00000, rt, imm}
  - JAL: {000011, target}
- Fields not used by a kind are ignored; for example, rd is ignored for ORI.
- words_written saturates at DEPTH.

Decomposition:
- Shared package (mips_isa_pkg): opcode and funct constants (R=000000, ADD=100000, SUB=100010, JR=001000, ORI, LW, SW, BEQ, LUI, JAL), the kind enum (4 bits), and the FSM state encoding. The existing control decoder reuses the same opcode and funct constants.
- Sub-module mips_word_pack: purely combinational kind+fields -> {word, legal}. The FSM, address counter and output register stay in the top module.

Test Plan:
- Reset, start, then ORI rs=0 rt=1 imm=0x1234 -> next cycle im_we=1, im_addr=0, im_wdata=0x34011234; words_written=1.
- Back-to-back beats with in_valid held high:
  - ADD rd=3 rs=1 rt=2 -> 0x00221820 at addr 0.
  - LW rt=4 rs=0 imm=8 -> 0x8C040008 at addr 1.
  - BEQ rs=1 rt=2 imm=0xFFFF -> 0x1022FFFF at addr 2.
  - JAL target=0xC00 -> 0x0C000C00 at addr 3.
  - JR rs=31 -> 0x03E00008 at addr 4.
  - Check: one write per cycle, no gaps.
- Illegal kind=12 between two LUI rt=1 imm=0xFFFF -> exactly two writes, both 0x3C01FFFF, at addr 0 and 1; err_illegal=1 until the next start.
- DEPTH=4: feed 6 beats -> 4 writes at addr 0-3; full=1 and in_ready=0 from the cycle after the 4th acceptance; finish -> IDLE with full=0.
- reset_n pulsed low mid-load with a write pending -> im_we=0 immediately and state IDLE; the next start writes at addr 0.
- start and in_valid asserted together in LOAD -> no write that cycle; the following beat is written at addr 0.

Source files
------------

// File: rtl/mips_isa_pkg.sv
// Shared ISA constants for the P4 core: opcodes, function codes, the
// symbolic instruction kinds accepted by the loader, and the loader FSM states.
package mips_isa_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_JR    = 6'b001000;

    typedef enum logic [3:0] {
        KIND_NOP = 4'd0,
        KIND_ADD = 4'd1,
        KIND_SUB = 4'd2,
        KIND_JR  = 4'd3,
        KIND_ORI = 4'd4,
        KIND_LW  = 4'd5,
        KIND_SW  = 4'd6,
        KIND_BEQ = 4'd7,
        KIND_LUI = 4'd8,
        KIND_JAL = 4'd9
    } kind_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2
    } load_state_e;

endpackage

// File: rtl/mips_word_pack.sv
// Combinational encoder: symbolic kind plus fields -> 32-bit MIPS word.
// Kinds 10-15 come back with legal=0 and a zero word.
module mips_word_pack
    import mips_isa_pkg::*;
(
    input  logic [3:0]  kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        legal
);

    // Field packing per kind; shamt is always zero, unused fields are dropped.
    always_comb begin
        word  = 32'h0;
        legal = 1'b1;
        case (kind_e'(kind))
            KIND_NOP: word = 32'h0;
            KIND_ADD: word = {OP_RTYPE, rs, rt, rd, 5'b0, FN_ADD};
            KIND_SUB: word = {OP_RTYPE, rs, rt, rd, 5'b0, FN_SUB};
            KIND_JR:  word = {OP_RTYPE, rs, 15'b0, FN_JR};
            KIND_ORI: word = {OP_ORI, rs, rt, imm};
            KIND_LW:  word = {OP_LW, rs, rt, imm};
            KIND_SW:  word = {OP_SW, rs, rt, imm};
            KIND_BEQ: word = {OP_BEQ, rs, rt, imm};
            KIND_LUI: word = {OP_LUI, 5'b0, rt, imm};
            KIND_JAL: word = {OP_JAL, target};
            default:  legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_instr_encoder.sv
// Program loader: accepts symbolic instructions, encodes them and writes
// the words sequentially into instruction memory starting at address 0.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | no load in progress, input stalled
//  LOAD    | accepting beats, one memory write per legal beat
//  FULL    | DEPTH words written, input stalled until finish or start
module mips_instr_encoder
    import mips_isa_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        kind,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              busy,
    output logic              full,
    output logic [ADDR_W:0]   words_written,
    output logic              err_illegal
);

    load_state_e      state;
    load_state_e      stateNext;
    logic [31:0]      packWord;
    logic             packLegal;
    logic             beatFire;
    logic             writeFire;
    logic             lastWord;

    mips_word_pack uPack (
        .kind   (kind),
        .rs     (rs),
        .rt     (rt),
        .rd     (rd),
        .imm    (imm),
        .target (target),
        .word   (packWord),
        .legal  (packLegal)
    );

    // start and finish both pre-empt a beat presented on the same cycle.
    assign in_ready  = (state == ST_LOAD);
    assign beatFire  = in_valid && (state == ST_LOAD) && !start && !finish;
    assign writeFire = beatFire && packLegal;
    assign lastWord  = (words_written == (ADDR_W+1)'(DEPTH - 1));
    assign busy      = (state != ST_IDLE);
    assign full      = (state == ST_FULL);

    // Next-state logic, priority start > finish > beat.
    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE: begin
                if (start) stateNext = ST_LOAD;
            end
            ST_LOAD: begin
                if (start)                      stateNext = ST_LOAD;
                else if (finish)                stateNext = ST_IDLE;
                else if (writeFire && lastWord) stateNext = ST_FULL;
            end
            ST_FULL: begin
                if (start)       stateNext = ST_LOAD;
                else if (finish) stateNext = ST_IDLE;
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= stateNext;
    end

    // Write port register, word counter and sticky illegal flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            im_we         <= 1'b0;
            im_addr       <= '0;
            im_wdata      <= 32'h0;
            words_written <= '0;
            err_illegal   <= 1'b0;
        end else begin
            im_we <= writeFire;
            if (start) begin
                words_written <= '0;
                err_illegal   <= 1'b0;
            end else if (writeFire) begin
                im_addr       <= words_written[ADDR_W-1:0];
                im_wdata      <= packWord;
                words_written <= words_written + 1'b1;
            end else if (beatFire) begin
                err_illegal   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mips_instr_encoder.sv
module tb_mips_instr_encoder;

    logic        clk;
    logic        reset_n;
    logic        startBig;
    logic        startSmall;
    logic        finish;
    logic        in_valid;
    logic [3:0]  kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] target;

    logic        rdyB, weB, busyB, fullB, errB;
    logic [9:0]  addrB;
    logic [31:0] wdB;
    logic [10:0] wwB;

    logic        rdyS, weS, busyS, fullS, errS;
    logic [1:0]  addrS;
    logic [31:0] wdS;
    logic [2:0]  wwS;

    int total = 0;
    int bad   = 0;

    // reference model, index 0 = DEPTH 1024 instance, 1 = DEPTH 4 instance
    int          mDepth[2];
    int          mSt[2];     // 0 idle, 1 loading, 2 full
    int          mCnt[2];
    bit          mErr[2];
    bit          mWe[2];
    int          mAddr[2];
    logic [31:0] mWd[2];

    mips_instr_encoder #(.DEPTH(1024), .ADDR_W(10)) dutBig (
        .clk(clk), .reset_n(reset_n), .start(startBig), .finish(finish),
        .in_valid(in_valid), .in_ready(rdyB), .kind(kind), .rs(rs), .rt(rt),
        .rd(rd), .imm(imm), .target(target), .im_we(weB), .im_addr(addrB),
        .im_wdata(wdB), .busy(busyB), .full(fullB), .words_written(wwB),
        .err_illegal(errB)
    );

    mips_instr_encoder #(.DEPTH(4), .ADDR_W(2)) dutSmall (
        .clk(clk), .reset_n(reset_n), .start(startSmall), .finish(finish),
        .in_valid(in_valid), .in_ready(rdyS), .kind(kind), .rs(rs), .rt(rt),
        .rd(rd), .imm(imm), .target(target), .im_we(weS), .im_addr(addrS),
        .im_wdata(wdS), .busy(busyS), .full(fullS), .words_written(wwS),
        .err_illegal(errS)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expectEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {legal, word} straight from the instruction-format table
    function automatic logic [32:0] encodeRef(input int k, input logic [4:0] s, input logic [4:0] t,
                                              input logic [4:0] d, input logic [15:0] i, input logic [25:0] tg);
        case (k)
            0: return {1'b1, 32'h0};
            1: return {1'b1, 6'd0, s, t, d, 5'd0, 6'd32};
            2: return {1'b1, 6'd0, s, t, d, 5'd0, 6'd34};
            3: return {1'b1, 6'd0, s, 15'd0, 6'd8};
            4: return {1'b1, 6'd13, s, t, i};
            5: return {1'b1, 6'd35, s, t, i};
            6: return {1'b1, 6'd43, s, t, i};
            7: return {1'b1, 6'd4, s, t, i};
            8: return {1'b1, 6'd15, 5'd0, t, i};
            9: return {1'b1, 6'd3, tg};
            default: return 33'h0;
        endcase
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            mSt[i] = 0; mCnt[i] = 0; mErr[i] = 0; mWe[i] = 0; mAddr[i] = 0; mWd[i] = 0;
        end
    endtask

    task automatic modelEdge(input int i, input logic st);
        logic [32:0] e;
        mWe[i] = 0;
        if (st) begin
            mSt[i] = 1; mCnt[i] = 0; mErr[i] = 0;
        end else if (finish) begin
            mSt[i] = 0;
        end else if (mSt[i] == 1 && in_valid) begin
            e = encodeRef(int'(kind), rs, rt, rd, imm, target);
            if (e[32]) begin
                mWe[i] = 1; mAddr[i] = mCnt[i]; mWd[i] = e[31:0];
                mCnt[i]++;
                if (mCnt[i] == mDepth[i]) mSt[i] = 2;
            end else begin
                mErr[i] = 1;
            end
        end
    endtask

    task automatic compareModel();
        expectEq("big.we",    weB,   mWe[0]);
        if (mWe[0]) begin
            expectEq("big.addr", addrB, mAddr[0]);
            expectEq("big.wdata", wdB,  mWd[0]);
        end
        expectEq("big.words", wwB,   mCnt[0]);
        expectEq("big.err",   errB,  mErr[0]);
        expectEq("big.full",  fullB, mSt[0] == 2);
        expectEq("big.busy",  busyB, mSt[0] != 0);
        expectEq("big.ready", rdyB,  mSt[0] == 1);
        expectEq("small.we",  weS,   mWe[1]);
        if (mWe[1]) begin
            expectEq("small.addr", addrS, mAddr[1]);
            expectEq("small.wdata", wdS,  mWd[1]);
        end
        expectEq("small.words", wwS,   mCnt[1]);
        expectEq("small.err",   errS,  mErr[1]);
        expectEq("small.full",  fullS, mSt[1] == 2);
        expectEq("small.busy",  busyS, mSt[1] != 0);
        expectEq("small.ready", rdyS,  mSt[1] == 1);
    endtask

    task automatic step();
        @(posedge clk);
        modelEdge(0, startBig);
        modelEdge(1, startSmall);
        #1;
        compareModel();
    endtask

    task automatic idleInputs();
        startBig = 0; startSmall = 0; finish = 0; in_valid = 0;
        kind = 0; rs = 0; rt = 0; rd = 0; imm = 0; target = 0;
    endtask

    task automatic setBeat(input int k, input int s, input int t, input int d, input int i, input int tg);
        in_valid = 1; kind = 4'(k); rs = 5'(s); rt = 5'(t); rd = 5'(d); imm = 16'(i); target = 26'(tg);
    endtask

    task automatic doStartBig();
        idleInputs(); startBig = 1; step(); startBig = 0;
    endtask

    task automatic doFinish();
        idleInputs(); finish = 1; step(); finish = 0;
    endtask

    task automatic applyReset();
        reset_n = 0;
        #1;
        modelReset();
        repeat (2) @(negedge clk);
        reset_n = 1;
    endtask

    task automatic beatBig(input string tag, input int k, input int s, input int t, input int d,
                           input int i, input int tg, input logic [31:0] expWord, input int expAddr);
        setBeat(k, s, t, d, i, tg);
        step();
        expectEq({tag, ".we"},    weB,   1);
        expectEq({tag, ".addr"},  addrB, expAddr);
        expectEq({tag, ".wdata"}, wdB,   expWord);
    endtask

    initial begin
        int smallWrites;
        mDepth[0] = 1024;
        mDepth[1] = 4;
        idleInputs();
        modelReset();
        reset_n = 0;
        #1;
        expectEq("reset.we",    weB,   0);
        expectEq("reset.busy",  busyB, 0);
        expectEq("reset.words", wwB,   0);
        expectEq("reset.ready", rdyB,  0);
        repeat (2) @(negedge clk);
        reset_n = 1;

        // single ORI
        doStartBig();
        beatBig("ori", 4, 0, 1, 0, 16'h1234, 0, 32'h34011234, 0);
        expectEq("ori.words", wwB, 1);
        doFinish();

        // back-to-back beats
        doStartBig();
        beatBig("add", 1, 1, 2, 3, 0, 0,      32'h00221820, 0);
        beatBig("lw",  5, 0, 4, 0, 8, 0,      32'h8C040008, 1);
        beatBig("beq", 7, 1, 2, 0, 16'hFFFF, 0, 32'h1022FFFF, 2);
        beatBig("jal", 9, 0, 0, 0, 0, 26'hC00, 32'h0C000C00, 3);
        beatBig("jr",  3, 31, 0, 0, 0, 0,     32'h03E00008, 4);
        expectEq("b2b.words", wwB, 5);
        doFinish();

        // illegal kind sandwiched between two LUIs
        doStartBig();
        beatBig("lui0", 8, 7, 1, 9, 16'hFFFF, 0, 32'h3C01FFFF, 0);
        setBeat(12, 1, 1, 1, 1, 1);
        step();
        expectEq("illegal.we",  weB,  0);
        expectEq("illegal.err", errB, 1);
        beatBig("lui1", 8, 0, 1, 0, 16'hFFFF, 0, 32'h3C01FFFF, 1);
        expectEq("illegal.words", wwB, 2);
        doFinish();
        idleInputs(); step();
        expectEq("illegal.sticky", errB, 1);
        doStartBig();
        expectEq("illegal.cleared", errB, 0);
        doFinish();

        // DEPTH=4 instance: six beats, only four land
        smallWrites = 0;
        idleInputs(); startSmall = 1; step(); startSmall = 0;
        for (int n = 0; n < 6; n++) begin
            setBeat(4, n, n + 1, 0, n * 3, 0);
            step();
            if (weS) begin
                expectEq("full.addr", addrS, smallWrites);
                smallWrites++;
            end
            if (n == 3) begin
                expectEq("full.flag",  fullS, 1);
                expectEq("full.ready", rdyS,  0);
            end
        end
        expectEq("full.count", smallWrites, 4);
        expectEq("full.words", wwS, 4);
        doFinish();
        expectEq("full.cleared", fullS, 0);
        expectEq("full.idle",    busyS, 0);

        // asynchronous reset with a write pending
        doStartBig();
        setBeat(4, 1, 2, 0, 16'h55AA, 0);
        step();
        expectEq("arst.pending", weB, 1);
        idleInputs();
        reset_n = 0;
        #1;
        modelReset();
        expectEq("arst.we",   weB,   0);
        expectEq("arst.busy", busyB, 0);
        expectEq("arst.words", wwB,  0);
        @(negedge clk);
        reset_n = 1;
        doStartBig();
        beatBig("arst.next", 5, 2, 3, 0, 16'h0010, 0, 32'h8C430010, 0);
        doFinish();

        // start together with a valid beat inside LOAD
        doStartBig();
        beatBig("sv.a", 1, 1, 2, 3, 0, 0, 32'h00221820, 0);
        beatBig("sv.b", 1, 1, 2, 3, 0, 0, 32'h00221820, 1);
        setBeat(4, 0, 1, 0, 16'h1234, 0);
        startBig = 1;
        step();
        startBig = 0;
        expectEq("sv.nowrite", weB, 0);
        expectEq("sv.words",   wwB, 0);
        beatBig("sv.next", 4, 0, 1, 0, 16'h1234, 0, 32'h34011234, 0);
        doFinish();

        // randomized traffic against the model on both instances
        applyReset();
        for (int c = 0; c < 600; c++) begin
            startBig   = ($urandom_range(0, 99) < 3);
            startSmall = ($urandom_range(0, 99) < 6);
            finish     = ($urandom_range(0, 99) < 3);
            in_valid   = ($urandom_range(0, 99) < 80);
            kind       = ($urandom_range(0, 99) < 85) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
            rs         = 5'($urandom);
            rt         = 5'($urandom);
            rd         = 5'($urandom);
            imm        = 16'($urandom);
            target     = 26'($urandom);
            step();
        end
        idleInputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
